// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: state encodings and
// default slot timing.
package seg_scan_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam int DEF_DIV       = 50000;
  localparam int DEF_BLANK_CYC = 2000;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter: runs 0..DIV-1 across one digit slot and flags the end of the
// blanking interval and the end of the slot.
module seg_scan_timer
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIV       = DEF_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr_i,
  output logic blank_done_o,
  output logic slot_done_o
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign blank_done_o = (cnt_q == BLANK_LAST);
  assign slot_done_o  = (cnt_q == SLOT_LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || slot_done_o) cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment
// display with double-buffered value, per-slot blanking and leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIG     = 4,
  parameter int DIV       = DEF_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               EN,
  input  logic               LOAD,
  input  logic [4*N_DIG-1:0] VALUE,
  input  logic [N_DIG-1:0]   DP_IN,
  input  logic               LZS,
  output logic [3:0]         NUM,
  output logic               DP,
  output logic [N_DIG-1:0]   AN,
  output logic               FRAME,
  output logic               PENDING
);

  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

  logic [1:0]               state_q, state_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [N_DIG-1:0][3:0]    sh_val_q, sh_val_d, dsp_val_q, dsp_val_d;
  logic [N_DIG-1:0]         sh_dp_q, sh_dp_d, dsp_dp_q, dsp_dp_d;
  logic [N_DIG-1:0]         an_q, an_d;
  logic [3:0]               num_q, num_d;
  logic                     dp_q, dp_d, frame_q, frame_d, pend_q, pend_d;
  logic                     blank_done, slot_done, frame_start, supp;
  logic [N_DIG-1:0]         lead0;

  seg_scan_timer #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) u_timer (
    .CLK          (CLK),
    .RST          (RST),
    .clr_i        ((state_q == S_IDLE) || !EN),
    .blank_done_o (blank_done),
    .slot_done_o  (slot_done)
  );

  // lead0[i]: display digits N_DIG-1..i are all zero
  for (genvar i = 0; i < N_DIG; i++) begin : g_lz
    if (i == N_DIG - 1) begin : g_top
      assign lead0[i] = (dsp_val_d[i] == 4'd0);
    end else begin : g_low
      assign lead0[i] = (dsp_val_d[i] == 4'd0) && lead0[i+1];
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_start = 1'b0;
    if (!EN) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_BLANK;
          idx_d       = '0;
          frame_start = 1'b1;
        end
        S_BLANK: if (blank_done) state_d = S_SHOW;
        S_SHOW: if (slot_done) begin
          state_d     = S_BLANK;
          idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
          frame_start = (idx_q == IDX_LAST);
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // A LOAD coinciding with a frame start still lets the old shadow transfer
  always_comb begin
    sh_val_d  = sh_val_q;
    sh_dp_d   = sh_dp_q;
    dsp_val_d = dsp_val_q;
    dsp_dp_d  = dsp_dp_q;
    pend_d    = pend_q;
    if (frame_start && pend_q) begin
      dsp_val_d = sh_val_q;
      dsp_dp_d  = sh_dp_q;
      pend_d    = 1'b0;
    end
    if (LOAD) begin
      sh_val_d = VALUE;
      sh_dp_d  = DP_IN;
      pend_d   = 1'b1;
    end
  end

  assign supp = LZS && (idx_d != '0) && lead0[idx_d];

  always_comb begin
    an_d    = '1;
    num_d   = num_q;
    dp_d    = dp_q;
    frame_d = frame_start;
    if (state_d == S_SHOW && !supp) an_d[idx_d] = 1'b0;
    if (state_d == S_BLANK && state_q != S_BLANK) begin
      num_d = dsp_val_d[idx_d];
      dp_d  = dsp_dp_d[idx_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      dsp_val_q <= '0;
      dsp_dp_q  <= '0;
      pend_q    <= 1'b0;
      an_q      <= '1;
      num_q     <= 4'd0;
      dp_q      <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      dsp_val_q <= dsp_val_d;
      dsp_dp_q  <= dsp_dp_d;
      pend_q    <= pend_d;
      an_q      <= an_d;
      num_q     <= num_d;
      dp_q      <= dp_d;
      frame_q   <= frame_d;
    end
  end

  assign AN      = an_q;
  assign NUM     = num_q;
  assign DP      = dp_q;
  assign FRAME   = frame_q;
  assign PENDING = pend_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIG=4, DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST, EN, LOAD, LZS;
  logic [15:0] VALUE;
  logic [3:0]  DP_IN;
  logic [3:0]  NUM, AN;
  logic        DP, FRAME, PENDING;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int t0     = 0;

  seg_scan_ctrl #(.N_DIG(4), .DIV(8), .BLANK_CYC(2)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .VALUE(VALUE), .DP_IN(DP_IN),
    .LZS(LZS), .NUM(NUM), .DP(DP), .AN(AN), .FRAME(FRAME), .PENDING(PENDING)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  // advance to cycle t0+c (relative to the current EN reference point)
  task automatic go(input int c);
    while (cyc < t0 + c) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at t+%0d: observed %h expected %h", tag, cyc - t0, obs, exp);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; LZS = 1'b0; VALUE = '0; DP_IN = '0;
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rst_an", 16'(AN), 16'hF);
    chk("rst_num", 16'(NUM), 16'h0);
    chk("rst_dp", 16'(DP), 16'h0);
    chk("rst_frame", 16'(FRAME), 16'h0);
    chk("rst_pend", 16'(PENDING), 16'h0);
    repeat (5) tick();
    chk("idle_an", 16'(AN), 16'hF);
    chk("idle_frame", 16'(FRAME), 16'h0);

    // load 1234 while idle, then enable
    VALUE = 16'h1234; DP_IN = 4'b0010; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("load_pend", 16'(PENDING), 16'h1);
    EN = 1'b1; t0 = cyc;
    go(1);
    chk("f1_frame", 16'(FRAME), 16'h1);
    chk("f1_an_blank", 16'(AN), 16'hF);
    chk("f1_pend_clr", 16'(PENDING), 16'h0);
    go(2);
    chk("f1_frame_pulse", 16'(FRAME), 16'h0);
    chk("f1_an_blank2", 16'(AN), 16'hF);
    go(3);
    chk("d0_an_first", 16'(AN), 16'hE);
    chk("d0_num", 16'(NUM), 16'h4);
    chk("d0_dp", 16'(DP), 16'h0);
    go(8);
    chk("d0_an_last", 16'(AN), 16'hE);
    go(9);
    chk("d1_blank_an", 16'(AN), 16'hF);
    chk("d1_num", 16'(NUM), 16'h3);
    chk("d1_dp", 16'(DP), 16'h1);
    go(11);
    chk("d1_an", 16'(AN), 16'hD);
    go(19);
    chk("d2_num", 16'(NUM), 16'h2);
    go(21);
    chk("d2_an", 16'(AN), 16'hB);
    go(29);
    chk("d3_num", 16'(NUM), 16'h1);
    go(31);
    chk("d3_an", 16'(AN), 16'h7);
    go(32);
    chk("f2_pre", 16'(FRAME), 16'h0);
    go(33);
    chk("f2_frame", 16'(FRAME), 16'h1);

    // mid-frame load of 5678
    go(36);
    VALUE = 16'h5678; DP_IN = 4'b0000; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("mid_pend", 16'(PENDING), 16'h1);
    chk("mid_num_old", 16'(NUM), 16'h4);
    go(41);
    chk("mid_d1_old", 16'(NUM), 16'h3);
    go(65);
    chk("f3_frame", 16'(FRAME), 16'h1);
    chk("f3_num_new", 16'(NUM), 16'h8);
    chk("f3_pend_clr", 16'(PENDING), 16'h0);
    go(67);
    chk("f3_an", 16'(AN), 16'hE);
    go(73);
    chk("f3_d1_num", 16'(NUM), 16'h7);

    // load of 9999 during a frame-start cycle
    go(97);
    chk("f4_frame", 16'(FRAME), 16'h1);
    VALUE = 16'h9999; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    chk("f4_pend", 16'(PENDING), 16'h1);
    chk("f4_num_old", 16'(NUM), 16'h8);
    go(105);
    chk("f4_d1_old", 16'(NUM), 16'h7);
    go(129);
    chk("f5_frame", 16'(FRAME), 16'h1);
    chk("f5_num_new", 16'(NUM), 16'h9);
    chk("f5_pend_clr", 16'(PENDING), 16'h0);

    // leading-zero suppression, value 0040
    go(130);
    VALUE = 16'h0040; LZS = 1'b1; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    go(163);
    chk("lz_d0_an", 16'(AN), 16'hE);
    chk("lz_d0_num", 16'(NUM), 16'h0);
    go(165);
    VALUE = 16'h0000; LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    go(169);
    chk("lz_d1_num", 16'(NUM), 16'h4);
    go(171);
    chk("lz_d1_an", 16'(AN), 16'hD);
    go(181);
    chk("lz_d2_supp", 16'(AN), 16'hF);
    go(188);
    chk("lz_d3_supp", 16'(AN), 16'hF);
    go(195);
    chk("lz0_d0_an", 16'(AN), 16'hE);
    go(203);
    chk("lz0_d1_supp", 16'(AN), 16'hF);

    // LZS off: digit 2 lights, then drop EN mid-show
    go(204);
    LZS = 1'b0;
    go(212);
    chk("en_d2_an", 16'(AN), 16'hB);
    EN = 1'b0;
    tick();
    chk("en_off_an", 16'(AN), 16'hF);
    chk("en_off_frame", 16'(FRAME), 16'h0);
    tick();
    chk("en_off_an2", 16'(AN), 16'hF);
    EN = 1'b1;
    tick();
    chk("re_frame", 16'(FRAME), 16'h1);
    chk("re_num", 16'(NUM), 16'h0);
    tick(); tick();
    chk("re_an_d0", 16'(AN), 16'hE);

    // reset mid-slot with a simultaneous LOAD
    tick(); tick();
    RST = 1'b1; VALUE = 16'h7777; LOAD = 1'b1;
    tick();
    chk("mrst_an", 16'(AN), 16'hF);
    chk("mrst_num", 16'(NUM), 16'h0);
    chk("mrst_dp", 16'(DP), 16'h0);
    chk("mrst_frame", 16'(FRAME), 16'h0);
    chk("mrst_pend", 16'(PENDING), 16'h0);
    RST = 1'b0; LOAD = 1'b0;
    tick();
    chk("post_rst_frame", 16'(FRAME), 16'h1);
    tick(); tick();
    chk("post_rst_an", 16'(AN), 16'hE);
    chk("post_rst_num", 16'(NUM), 16'h0);
    chk("post_rst_pend", 16'(PENDING), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
